branch_pred_tracker: RTL and testbench
======================================

Name: branch_pred_tracker

Overview:
Fetch-side companion to bht_btb_controller. It owns the fetch PC register and drives pc_fetch into the predictor. It carries each fetch's prediction metadata down a shift pipeline to execute. There it compares the prediction against the resolved outcome and produces the registered update bundle (pc_fetch_update, pc_target_update, is_branch, prev_counter, prev_valid, increment_counter) consumed by the controller, plus redirect/flush on misprediction.

Parameters:
COUNTER_BITS, 2, width of history counter carried per entry
PIPE_DEPTH, 2, number of tracked stages from fetch to execute (>=1)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC and pipeline; ex_* ignored this cycle
pc_fetch  out  32  current fetch PC (to predictor and instruction memory)
branch_prediction  in  1  predictor says taken for pc_fetch
pc_target_prediction  in  32  predicted target for pc_fetch
current_counter  in  COUNTER_BITS  counter read for pc_fetch
current_valid  in  1  valid bit read for pc_fetch
ex_valid  in  1  execute holds a real instruction this cycle
ex_is_branch  in  1  executing instruction is a conditional branch
ex_taken  in  1  resolved direction
ex_target  in  32  resolved branch target
pc_fetch_update  out  32  registered: PC of retired branch
pc_target_update  out  32  registered: resolved target
is_branch  out  1  registered: write strobe to controller
prev_counter  out  COUNTER_BITS  registered: counter captured at fetch
prev_valid  out  1  registered: valid bit captured at fetch
increment_counter  out  1  registered: = ex_taken of retired branch
mispredict  out  1  combinational: redirect this cycle
redirect_pc  out  32  combinational: correct next PC when mispredict=1
flush  out  1  combinational: = mispredict; younger stages must squash

Behaviour:
- Reset (async, rst=1): pc_fetch=RESET_PC; all entries invalid; all registered outputs 0; mispredict/flush 0.
- Entry fields: valid, pc, pred_taken, pred_target, counter, cvalid. Entry 0 = fetch capture; entry PIPE_DEPTH-1 = tail (execute).
- Per cycle with stall=0: entries shift by one; entry 0 loads {1, pc_fetch, branch_prediction, pc_target_prediction, current_counter, current_valid}.
- Resolve when tail.valid & ex_valid & !stall:
  - actual_next = ex_is_branch&ex_taken ? ex_target : tail.pc+4.
  - pred_next = tail.pred_taken ? tail.pred_target : tail.pc+4.
  - mispredict = (actual_next != pred_next). This includes a predicted-taken non-branch, caused by tag alias; redirect goes to pc+4.
  - redirect_pc = actual_next.
- Next PC priority: rst > stall (hold) > mispredict (redirect_pc) > branch_prediction (pc_target_prediction) > pc_fetch+4. Adds wrap modulo 2^32.
- On mispredict: all entries except tail are cleared invalid next edge. Entry 0 still loads the redirected fetch one cycle later, not the wrong-path fetch.
- Update bundle, 1-cycle latency after resolve: is_branch=1 only if resolve & ex_is_branch. Other fields hold their last value when is_branch=0.
- Tail invalid or ex_valid=0: no resolve, mispredict=0, is_branch=0 next cycle.
- stall=1: everything holds and is_branch drops to 0 next cycle. A stall in the resolve cycle defers resolution until stall releases.
- PIPE_DEPTH=1: entry 0 is the tail; no younger entries to clear.

Optional Feature:
BRANCH_STATS_EN:
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0]. They count resolved branches and mispredicts, are cleared by rst and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg: COUNTER_BITS default, entry struct/type (valid, pc, pred_taken, pred_target, counter, cvalid), PC_INC=4, RESET_PC default.
- One natural sub-module, bp_entry_pipe: parameterised PIPE_DEPTH shift register with stall and flush-younger.
- Compare, next-PC mux and update registers stay in the top.

Test Plan:
- Reset: assert rst mid-run -> pc_fetch=0 immediately; is_branch=0; tail invalid; first ex_valid ignored until PIPE_DEPTH fetches have elapsed.
- Sequential fetch: no prediction, stall=0 -> pc_fetch 0,4,8,C. Then ex_valid on a non-branch with pred_taken=0 -> mispredict=0, is_branch stays 0.
- Correct taken: PC 0x10 predicted taken to 0x40 (counter=2'b10). Resolve taken to 0x40 -> mispredict=0. Next cycle: is_branch=1, pc_fetch_update=0x10, pc_target_update=0x40, prev_counter=2'b10, increment_counter=1.
- Not-taken mispredict: PC 0x20 predicted taken to 0x80, resolved not taken -> mispredict=1, redirect_pc=0x24. Next cycle: pc_fetch=0x24, younger entries invalid, increment_counter=0.
- Alias: predicted-taken non-branch at 0x30 -> mispredict=1, redirect_pc=0x34, is_branch=0.
- Stall during resolve: stall=1 with a mispredicting tail -> mispredict=0, PC held. Release stall -> mispredict=1 in that cycle. With BRANCH_STATS_EN, stat_mispredicts increments by exactly 1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch prediction tracker.
package bp_pkg;

    localparam int          COUNTER_BITS_DEF = 2;
    localparam int          CNT_MAX          = 8;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;

    // The counter field is sized for the widest supported counter and narrowed at the top.
    typedef struct packed {
        logic               valid;
        logic [31:0]        pc;
        logic               pred_taken;
        logic [31:0]        pred_target;
        logic [CNT_MAX-1:0] counter;
        logic               cvalid;
    } bp_entry_t;

    function automatic logic [31:0] pred_next_pc(input bp_entry_t e);
        return e.pred_taken ? e.pred_target : e.pc + PC_INC;
    endfunction

endpackage

// File: rtl/bp_entry_pipe.sv
// Shift pipeline carrying fetch prediction metadata from fetch (entry 0) to execute (tail).
module bp_entry_pipe
    import bp_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      flush,
    input  bp_entry_t entry_in,
    output bp_entry_t tail
);

    bp_entry_t stages [PIPE_DEPTH];

    // On flush the tail retires and every younger entry is wrong-path, so nothing valid survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stages[i] <= '0;
        end else if (!stall) begin
            if (flush) begin
                for (int i = 0; i < PIPE_DEPTH; i++) stages[i] <= '0;
            end else begin
                stages[0] <= entry_in;
                for (int i = 1; i < PIPE_DEPTH; i++) stages[i] <= stages[i-1];
            end
        end
    end

    assign tail = stages[PIPE_DEPTH-1];

endmodule

// File: rtl/branch_pred_tracker.sv
// Fetch PC owner and prediction checker feeding the BHT/BTB controller update port.
// Optional BRANCH_STATS_EN adds saturating branch and mispredict counters.
module branch_pred_tracker
    import bp_pkg::*;
#(
    parameter int          COUNTER_BITS = COUNTER_BITS_DEF,
    parameter int          PIPE_DEPTH   = 2,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    output logic [31:0]             pc_fetch,
    input  logic                    branch_prediction,
    input  logic [31:0]             pc_target_prediction,
    input  logic [COUNTER_BITS-1:0] current_counter,
    input  logic                    current_valid,
    input  logic                    ex_valid,
    input  logic                    ex_is_branch,
    input  logic                    ex_taken,
    input  logic [31:0]             ex_target,
    output logic [31:0]             pc_fetch_update,
    output logic [31:0]             pc_target_update,
    output logic                    is_branch,
    output logic [COUNTER_BITS-1:0] prev_counter,
    output logic                    prev_valid,
    output logic                    increment_counter,
    output logic                    mispredict,
    output logic [31:0]             redirect_pc,
    output logic                    flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_mispredicts
`endif
);

    bp_entry_t   fetch_entry;
    bp_entry_t   tail;
    logic        resolve;
    logic [31:0] actual_next;
    logic [31:0] pred_next;

    always_comb begin
        fetch_entry             = '0;
        fetch_entry.valid       = 1'b1;
        fetch_entry.pc          = pc_fetch;
        fetch_entry.pred_taken  = branch_prediction;
        fetch_entry.pred_target = pc_target_prediction;
        fetch_entry.counter     = CNT_MAX'(current_counter);
        fetch_entry.cvalid      = current_valid;
    end

    bp_entry_pipe #(.PIPE_DEPTH(PIPE_DEPTH)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (mispredict),
        .entry_in (fetch_entry),
        .tail     (tail)
    );

    // A predicted-taken non-branch (tag alias) also mismatches and redirects to pc+4.
    always_comb begin
        resolve     = tail.valid & ex_valid & ~stall;
        actual_next = (ex_is_branch & ex_taken) ? ex_target : tail.pc + PC_INC;
        pred_next   = pred_next_pc(tail);
        mispredict  = resolve & (actual_next != pred_next);
    end

    assign redirect_pc = actual_next;
    assign flush       = mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    pc_fetch <= RESET_PC;
        else if (stall)             pc_fetch <= pc_fetch;
        else if (mispredict)        pc_fetch <= redirect_pc;
        else if (branch_prediction) pc_fetch <= pc_target_prediction;
        else                        pc_fetch <= pc_fetch + PC_INC;
    end

    // Payload fields only change on a retiring branch so the controller sees stable values otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_branch         <= 1'b0;
            pc_fetch_update   <= '0;
            pc_target_update  <= '0;
            prev_counter      <= '0;
            prev_valid        <= 1'b0;
            increment_counter <= 1'b0;
        end else begin
            is_branch <= resolve & ex_is_branch;
            if (resolve & ex_is_branch) begin
                pc_fetch_update   <= tail.pc;
                pc_target_update  <= ex_target;
                prev_counter      <= COUNTER_BITS'(tail.counter);
                prev_valid        <= tail.cvalid;
                increment_counter <= ex_taken;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve & ex_is_branch && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_tracker.sv
// Self-checking bench for branch_pred_tracker: directed scenarios plus a randomized run
// against a queue-based model of in-flight fetches.
module tb_branch_pred_tracker;

    localparam int D  = 2;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic [31:0]   pc_fetch;
    logic          branch_prediction = 1'b0;
    logic [31:0]   pc_target_prediction = '0;
    logic [CB-1:0] current_counter = '0;
    logic          current_valid = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_is_branch = 1'b0;
    logic          ex_taken = 1'b0;
    logic [31:0]   ex_target = '0;
    logic [31:0]   pc_fetch_update;
    logic [31:0]   pc_target_update;
    logic          is_branch;
    logic [CB-1:0] prev_counter;
    logic          prev_valid;
    logic          increment_counter;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic          flush;
`ifdef BRANCH_STATS_EN
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;
`endif

    int checks = 0;
    int passed = 0;

    branch_pred_tracker #(.COUNTER_BITS(CB), .PIPE_DEPTH(D), .RESET_PC(32'h0)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .pc_fetch             (pc_fetch),
        .branch_prediction    (branch_prediction),
        .pc_target_prediction (pc_target_prediction),
        .current_counter      (current_counter),
        .current_valid        (current_valid),
        .ex_valid             (ex_valid),
        .ex_is_branch         (ex_is_branch),
        .ex_taken             (ex_taken),
        .ex_target            (ex_target),
        .pc_fetch_update      (pc_fetch_update),
        .pc_target_update     (pc_target_update),
        .is_branch            (is_branch),
        .prev_counter         (prev_counter),
        .prev_valid           (prev_valid),
        .increment_counter    (increment_counter),
        .mispredict           (mispredict),
        .redirect_pc          (redirect_pc),
        .flush                (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches        (stat_branches),
        .stat_mispredicts     (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        stall = 1'b0;
        branch_prediction = 1'b0;
        pc_target_prediction = '0;
        current_counter = '0;
        current_valid = 1'b0;
        ex_valid = 1'b0;
        ex_is_branch = 1'b0;
        ex_taken = 1'b0;
        ex_target = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // From a fresh reset: steer fetch to x, fetch x with the given prediction, then walk it to the tail.
    task automatic fetch_at(input logic [31:0] x, input logic pt, input logic [31:0] tgt,
                            input logic [CB-1:0] cnt, input logic cv);
        branch_prediction = 1'b1;
        pc_target_prediction = x;
        tick();
        branch_prediction = pt;
        pc_target_prediction = tgt;
        current_counter = cnt;
        current_valid = cv;
        tick();
        branch_prediction = 1'b0;
        current_counter = '0;
        current_valid = 1'b0;
        repeat (D - 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            branch_prediction = 1'($urandom);
            pc_target_prediction = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        ex_valid = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken = 1'b1;
        ex_target = 32'h200;
        rst = 1'b1;
        #1;
        checks++;
        if (pc_fetch !== 32'h0) $display("[TB] FAIL reset_pc: got %h want %h", pc_fetch, 32'h0);
        else passed++;
        checks++;
        if (is_branch !== 1'b0) $display("[TB] FAIL reset_is_branch: got %b want 0", is_branch);
        else passed++;
        checks++;
        if (mispredict !== 1'b0 || flush !== 1'b0)
            $display("[TB] FAIL reset_mispredict: got %b/%b want 0/0", mispredict, flush);
        else passed++;
        #1;
        rst = 1'b0;
        branch_prediction = 1'b0;
        for (int i = 0; i < D; i++) begin
            #1;
            checks++;
            if (mispredict !== 1'b0) $display("[TB] FAIL reset_tail_invalid_%0d: got %b want 0", i, mispredict);
            else passed++;
            tick();
        end
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h200)
            $display("[TB] FAIL reset_first_resolve: got %b/%h want 1/%h", mispredict, redirect_pc, 32'h200);
        else passed++;
        quiet_inputs();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_fetch !== 32'(4 * i)) $display("[TB] FAIL seq_pc_%0d: got %h want %h", i, pc_fetch, 32'(4 * i));
            else passed++;
            tick();
        end
        ex_valid = 1'b1;
        ex_is_branch = 1'b0;
        #1;
        checks++;
        if (mispredict !== 1'b0) $display("[TB] FAIL seq_nonbranch_mp: got %b want 0", mispredict);
        else passed++;
        tick();
        checks++;
        if (is_branch !== 1'b0) $display("[TB] FAIL seq_nonbranch_isb: got %b want 0", is_branch);
        else passed++;
        quiet_inputs();
    endtask

    task automatic test_correct_taken();
        do_reset();
        fetch_at(32'h10, 1'b1, 32'h40, 2'b10, 1'b1);
        ex_valid = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken = 1'b1;
        ex_target = 32'h40;
        #1;
        checks++;
        if (mispredict !== 1'b0) $display("[TB] FAIL taken_mp: got %b want 0", mispredict);
        else passed++;
        tick();
        quiet_inputs();
        checks++;
        if (is_branch !== 1'b1 || pc_fetch_update !== 32'h10 || pc_target_update !== 32'h40)
            $display("[TB] FAIL taken_update: got %b/%h/%h want 1/10/40", is_branch, pc_fetch_update, pc_target_update);
        else passed++;
        checks++;
        if (prev_counter !== 2'b10 || prev_valid !== 1'b1 || increment_counter !== 1'b1)
            $display("[TB] FAIL taken_counter: got %b/%b/%b want 10/1/1", prev_counter, prev_valid, increment_counter);
        else passed++;
        tick();
        checks++;
        if (is_branch !== 1'b0 || pc_fetch_update !== 32'h10)
            $display("[TB] FAIL taken_hold: got %b/%h want 0/10", is_branch, pc_fetch_update);
        else passed++;
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        fetch_at(32'h20, 1'b1, 32'h80, 2'b11, 1'b1);
        ex_valid = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken = 1'b0;
        ex_target = 32'h80;
        #1;
        checks++;
        if (mispredict !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h24)
            $display("[TB] FAIL nt_mp: got %b/%b/%h want 1/1/24", mispredict, flush, redirect_pc);
        else passed++;
        tick();
        checks++;
        if (pc_fetch !== 32'h24) $display("[TB] FAIL nt_redirect_pc: got %h want 24", pc_fetch);
        else passed++;
        checks++;
        if (is_branch !== 1'b1 || increment_counter !== 1'b0 || pc_fetch_update !== 32'h20 || prev_counter !== 2'b11)
            $display("[TB] FAIL nt_update: got %b/%b/%h/%b want 1/0/20/11",
                     is_branch, increment_counter, pc_fetch_update, prev_counter);
        else passed++;
        ex_taken = 1'b1;
        ex_target = 32'h100;
        for (int i = 0; i < D; i++) begin
            #1;
            checks++;
            if (mispredict !== 1'b0) $display("[TB] FAIL nt_squashed_%0d: got %b want 0", i, mispredict);
            else passed++;
            tick();
        end
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h100)
            $display("[TB] FAIL nt_redirected_fetch: got %b/%h want 1/100", mispredict, redirect_pc);
        else passed++;
        quiet_inputs();
    endtask

    task automatic test_alias();
        do_reset();
        fetch_at(32'h30, 1'b1, 32'h90, 2'b00, 1'b0);
        ex_valid = 1'b1;
        ex_is_branch = 1'b0;
        ex_taken = 1'b1;
        ex_target = 32'h90;
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h34)
            $display("[TB] FAIL alias_mp: got %b/%h want 1/34", mispredict, redirect_pc);
        else passed++;
        tick();
        quiet_inputs();
        checks++;
        if (is_branch !== 1'b0 || pc_fetch !== 32'h34)
            $display("[TB] FAIL alias_after: got %b/%h want 0/34", is_branch, pc_fetch);
        else passed++;
    endtask

    task automatic test_stall_resolve();
        logic [31:0] held;
`ifdef BRANCH_STATS_EN
        logic [31:0] mp_before;
`endif
        do_reset();
        fetch_at(32'h20, 1'b1, 32'h80, 2'b01, 1'b1);
        held = 32'h80 + 32'(4 * (D - 1));
`ifdef BRANCH_STATS_EN
        mp_before = stat_mispredicts;
`endif
        stall = 1'b1;
        ex_valid = 1'b1;
        ex_is_branch = 1'b1;
        ex_taken = 1'b0;
        ex_target = 32'h80;
        branch_prediction = 1'b1;
        pc_target_prediction = 32'h500;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (mispredict !== 1'b0) $display("[TB] FAIL stall_mp_%0d: got %b want 0", i, mispredict);
            else passed++;
            tick();
            checks++;
            if (pc_fetch !== held || is_branch !== 1'b0)
                $display("[TB] FAIL stall_hold_%0d: got %h/%b want %h/0", i, pc_fetch, is_branch, held);
            else passed++;
        end
        stall = 1'b0;
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h24)
            $display("[TB] FAIL stall_release_mp: got %b/%h want 1/24", mispredict, redirect_pc);
        else passed++;
        tick();
        quiet_inputs();
        checks++;
        if (pc_fetch !== 32'h24 || is_branch !== 1'b1)
            $display("[TB] FAIL stall_release_after: got %h/%b want 24/1", pc_fetch, is_branch);
        else passed++;
`ifdef BRANCH_STATS_EN
        checks++;
        if (stat_mispredicts !== mp_before + 32'd1)
            $display("[TB] FAIL stall_stat_mp: got %0d want %0d", stat_mispredicts, mp_before + 32'd1);
        else passed++;
`endif
    endtask

    typedef struct {
        logic [31:0]   pc;
        logic          pt;
        logic [31:0]   tgt;
        logic [CB-1:0] cnt;
        logic          cv;
    } rec_t;

    // Model: a queue of in-flight fetches; the oldest reaches execute once D fetches are in flight.
    task automatic test_random();
        rec_t          q[$];
        rec_t          t, r;
        logic [31:0]   m_pc = 32'h0;
        logic          m_isb = 1'b0;
        logic [31:0]   m_upc = '0, m_utgt = '0;
        logic [CB-1:0] m_cnt = '0;
        logic          m_cv = 1'b0, m_inc = 1'b0;
        logic          tv, res, mp;
        logic [31:0]   an, pn;
        int            errs_before;
`ifdef BRANCH_STATS_EN
        logic [31:0]   m_sb = '0, m_sm = '0;
`endif
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            stall = ($urandom % 8) == 0;
            branch_prediction = 1'($urandom);
            pc_target_prediction = $urandom & 32'hFFFF_FFFC;
            current_counter = CB'($urandom);
            current_valid = 1'($urandom);
            ex_valid = ($urandom % 4) != 0;
            ex_is_branch = 1'($urandom);
            ex_taken = 1'($urandom);
            tv = (q.size() == D);
            t = '{default: '0};
            if (tv) t = q[0];
            case ($urandom % 3)
                0:       ex_target = t.tgt;
                1:       ex_target = t.pc + 32'd4;
                default: ex_target = $urandom & 32'hFFFF_FFFC;
            endcase
            res = tv && ex_valid && !stall;
            an = (ex_is_branch && ex_taken) ? ex_target : t.pc + 32'd4;
            pn = t.pt ? t.tgt : t.pc + 32'd4;
            mp = res && (an != pn);
            #1;
            checks++;
            if (mispredict !== mp || flush !== mp || (mp && redirect_pc !== an))
                $display("[TB] FAIL rand_mp cyc %0d: got %b/%b/%h want %b/%b/%h",
                         cyc, mispredict, flush, redirect_pc, mp, mp, an);
            else passed++;
            if (stall) begin
                m_isb = 1'b0;
            end else begin
                m_isb = res && ex_is_branch;
                if (m_isb) begin
                    m_upc = t.pc;
                    m_utgt = ex_target;
                    m_cnt = t.cnt;
                    m_cv = t.cv;
                    m_inc = ex_taken;
                end
`ifdef BRANCH_STATS_EN
                if (m_isb && m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 32'd1;
                if (mp && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 32'd1;
`endif
                if (mp) begin
                    q.delete();
                end else begin
                    r.pc = m_pc;
                    r.pt = branch_prediction;
                    r.tgt = pc_target_prediction;
                    r.cnt = current_counter;
                    r.cv = current_valid;
                    q.push_back(r);
                    if (q.size() > D) void'(q.pop_front());
                end
                m_pc = mp ? an : (branch_prediction ? pc_target_prediction : m_pc + 32'd4);
            end
            tick();
            errs_before = checks - passed;
            checks++;
            if (pc_fetch !== m_pc) $display("[TB] FAIL rand_pc cyc %0d: got %h want %h", cyc, pc_fetch, m_pc);
            else passed++;
            checks++;
            if (is_branch !== m_isb || pc_fetch_update !== m_upc || pc_target_update !== m_utgt ||
                prev_counter !== m_cnt || prev_valid !== m_cv || increment_counter !== m_inc)
                $display("[TB] FAIL rand_update cyc %0d: got %b/%h/%h/%b/%b/%b want %b/%h/%h/%b/%b/%b", cyc,
                         is_branch, pc_fetch_update, pc_target_update, prev_counter, prev_valid, increment_counter,
                         m_isb, m_upc, m_utgt, m_cnt, m_cv, m_inc);
            else passed++;
`ifdef BRANCH_STATS_EN
            checks++;
            if (stat_branches !== m_sb || stat_mispredicts !== m_sm)
                $display("[TB] FAIL rand_stats cyc %0d: got %0d/%0d want %0d/%0d",
                         cyc, stat_branches, stat_mispredicts, m_sb, m_sm);
            else passed++;
`endif
            if (checks - passed > errs_before + 20) break;
        end
        quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        tick();
        test_reset();
        test_sequential();
        test_correct_taken();
        test_mispredict_not_taken();
        test_alias();
        test_stall_resolve();
        test_random();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
